// File: rtl/defines.sv
// Shared writeback types: ALU/LSU result bundles, predictor update record,
// write-source select and the LSU result queue depth.
package defines;

  localparam int unsigned WB_LSU_FIFO_DEPTH = 2;

  typedef struct packed {
    logic        do_branch;
    logic [31:0] branch_target;
    logic [31:0] control_flow_pc;
    logic        icache_invalidate;
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } alu_wb_inf_t;

  typedef struct packed {
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } lsu_wb_inf_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
  } btp_update_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LSU
  } wb_src_e;

  // x0 is hardwired; a write to it is consumed but never reaches the file.
  function automatic logic writes_reg(input logic register_write, input logic [4:0] rd);
    return register_write && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO for queued load results; exposes its registered
// occupancy so the producer handshake can be derived from a flop.
module wb_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push   = push && (count != CNT_W'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: ALU-priority register-file write port, queued LSU results,
// redirect flops and optional predictor training (macro WB_BTP_UPDATE_EN).
module writeback
  import defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  alu_wb_inf_t alu_wb_inf,
  input  logic        lsu_valid,
  input  lsu_wb_inf_t lsu_wb_inf,
  output logic        lsu_ready,
  output logic        rf_write_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        wb_do_branch,
  output logic [31:0] wb_branch_target,
  output logic        wb_icache_invalidate,
  output logic        btp_update_valid,
  output logic [31:0] btp_update_pc,
  output logic [31:0] btp_update_target
);

  localparam int unsigned CNT_W = $clog2(WB_LSU_FIFO_DEPTH + 1);

  logic             alu_req;
  logic             redirect;
  logic             active;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  lsu_wb_inf_t      fifo_head;
  wb_src_e          src;

  assign alu_req  = alu_valid && alu_wb_inf.register_write;
  assign redirect = alu_valid && alu_wb_inf.do_branch;

  // Held low through reset and for the edge that releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active <= 1'b0;
    else      active <= 1'b1;
  end

  assign lsu_ready = active && (fifo_count < CNT_W'(WB_LSU_FIFO_DEPTH));
  assign fifo_push = lsu_valid && lsu_ready;

  // Only registered entries are eligible, so a load never bypasses the queue.
  always_comb begin
    src = WB_SRC_NONE;
    if (alu_req)                 src = WB_SRC_ALU;
    else if (fifo_count != '0)   src = WB_SRC_LSU;
  end

  assign fifo_pop = (src == WB_SRC_LSU);

  wb_fifo #(
    .WIDTH ($bits(lsu_wb_inf_t)),
    .DEPTH (WB_LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data (lsu_wb_inf),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_en <= 1'b0;
      rf_rd       <= '0;
      rf_data     <= '0;
    end else begin
      unique case (src)
        WB_SRC_ALU: begin
          rf_write_en <= writes_reg(alu_wb_inf.register_write, alu_wb_inf.rd);
          rf_rd       <= alu_wb_inf.rd;
          rf_data     <= alu_wb_inf.exe_result;
        end
        WB_SRC_LSU: begin
          rf_write_en <= writes_reg(fifo_head.register_write, fifo_head.rd);
          rf_rd       <= fifo_head.rd;
          rf_data     <= fifo_head.result;
        end
        default: rf_write_en <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_do_branch         <= 1'b0;
      wb_icache_invalidate <= 1'b0;
      wb_branch_target     <= '0;
    end else begin
      wb_do_branch         <= redirect;
      wb_icache_invalidate <= redirect && alu_wb_inf.icache_invalidate;
      if (redirect) wb_branch_target <= alu_wb_inf.branch_target;
    end
  end

`ifdef WB_BTP_UPDATE_EN
  btp_update_t btp_q;
  logic        btp_train;

  assign btp_train = redirect && !alu_wb_inf.icache_invalidate;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btp_q <= '0;
    end else begin
      btp_q.valid <= btp_train;
      if (btp_train) begin
        btp_q.pc     <= alu_wb_inf.control_flow_pc;
        btp_q.target <= alu_wb_inf.branch_target;
      end
    end
  end

  assign btp_update_valid  = btp_q.valid;
  assign btp_update_pc     = btp_q.pc;
  assign btp_update_target = btp_q.target;
`else
  logic unused_btp_pc;

  assign unused_btp_pc     = ^alu_wb_inf.control_flow_pc;
  assign btp_update_valid  = 1'b0;
  assign btp_update_pc     = '0;
  assign btp_update_target = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: stimulus predicts each register-file write
// into a queue; a negedge monitor pops and compares every observed write.
module tb_writeback;
  import defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  alu_wb_inf_t alu_wb_inf;
  logic        lsu_valid;
  lsu_wb_inf_t lsu_wb_inf;
  logic        lsu_ready;
  logic        rf_write_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        wb_do_branch;
  logic [31:0] wb_branch_target;
  logic        wb_icache_invalidate;
  logic        btp_update_valid;
  logic [31:0] btp_update_pc;
  logic [31:0] btp_update_target;

`ifdef WB_BTP_UPDATE_EN
  localparam bit BTP_ON = 1'b1;
`else
  localparam bit BTP_ON = 1'b0;
`endif

  writeback dut (
    .clk                  (clk),
    .rst                  (rst),
    .alu_valid            (alu_valid),
    .alu_wb_inf           (alu_wb_inf),
    .lsu_valid            (lsu_valid),
    .lsu_wb_inf           (lsu_wb_inf),
    .lsu_ready            (lsu_ready),
    .rf_write_en          (rf_write_en),
    .rf_rd                (rf_rd),
    .rf_data              (rf_data),
    .wb_do_branch         (wb_do_branch),
    .wb_branch_target     (wb_branch_target),
    .wb_icache_invalidate (wb_icache_invalidate),
    .btp_update_valid     (btp_update_valid),
    .btp_update_pc        (btp_update_pc),
    .btp_update_target    (btp_update_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  wr_t         exp_q[$];
  lsu_wb_inf_t lsu_model[$];
  wr_t         mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && rf_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(rf_write_en), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rf_write", {rf_rd, rf_data}, {mon_e.rd, mon_e.data});
      end
    end
  end

  function automatic alu_wb_inf_t alu(input logic [4:0] rd, input logic [31:0] data);
    alu_wb_inf_t r;
    r = '0;
    r.register_write = 1'b1;
    r.rd             = rd;
    r.exe_result     = data;
    return r;
  endfunction

  function automatic lsu_wb_inf_t lsu(input logic [4:0] rd, input logic [31:0] data);
    lsu_wb_inf_t r;
    r.register_write = 1'b1;
    r.rd             = rd;
    r.result         = data;
    return r;
  endfunction

  // One cycle of stimulus plus the reference model of arbitration and queueing.
  task automatic step(input logic av, input alu_wb_inf_t a, input logic lv, input lsu_wb_inf_t l);
    logic        acc;
    wr_t         w;
    lsu_wb_inf_t h;
    check("lsu_ready", 64'(lsu_ready), 64'(lsu_model.size() < 2));
    acc        = lv && (lsu_model.size() < 2);
    alu_valid  = av;
    alu_wb_inf = a;
    lsu_valid  = lv;
    lsu_wb_inf = l;
    if (av && a.register_write) begin
      if (a.rd != 5'd0) begin
        w.rd = a.rd; w.data = a.exe_result; exp_q.push_back(w);
      end
    end else if (lsu_model.size() != 0) begin
      h = lsu_model.pop_front();
      if (h.register_write && h.rd != 5'd0) begin
        w.rd = h.rd; w.data = h.result; exp_q.push_back(w);
      end
    end
    if (acc) lsu_model.push_back(l);
    @(posedge clk); #1;
    alu_valid  = 1'b0;
    lsu_valid  = 1'b0;
    alu_wb_inf = '0;
    lsu_wb_inf = '0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rf_write_en"}, 64'(rf_write_en), 64'h0);
    check({tag, "_rf_rd"}, 64'(rf_rd), 64'h0);
    check({tag, "_rf_data"}, 64'(rf_data), 64'h0);
    check({tag, "_lsu_ready"}, 64'(lsu_ready), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_wb_inf_t b;
    lsu_wb_inf_t z;

    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; alu_wb_inf = '0; lsu_wb_inf = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_wb_do_branch", 64'(wb_do_branch), 64'h0);
    check("reset_wb_branch_target", 64'(wb_branch_target), 64'h0);
    check("reset_wb_icache_invalidate", 64'(wb_icache_invalidate), 64'h0);
    check("reset_btp_valid", 64'(btp_update_valid), 64'h0);
    check("reset_btp_pc", 64'(btp_update_pc), 64'h0);
    check("reset_btp_target", 64'(btp_update_target), 64'h0);

    rst = 1'b1;
    #1;
    check("ready_before_first_edge", 64'(lsu_ready), 64'h0);
    @(posedge clk); #1;
    check("ready_after_first_edge", 64'(lsu_ready), 64'h1);

    // ALU-only write, one cycle latency
    step(1'b1, alu(5'd5, 32'h1234), 1'b0, '0);
    check("alu_we", 64'(rf_write_en), 64'h1);
    check("alu_rd", 64'(rf_rd), 64'd5);
    check("alu_data", 64'(rf_data), 64'h1234);

    // x0 destination never writes
    step(1'b1, alu(5'd0, 32'hFFFF), 1'b0, '0);
    check("x0_we", 64'(rf_write_en), 64'h0);

    // ALU/LSU conflict
    step(1'b1, alu(5'd3, 32'hA), 1'b1, lsu(5'd4, 32'hB));
    check("conflict_c1_rd", 64'(rf_rd), 64'd3);
    idle();
    check("conflict_c2_we", 64'(rf_write_en), 64'h1);
    check("conflict_c2_rd", 64'(rf_rd), 64'd4);
    check("conflict_c2_data", 64'(rf_data), 64'hB);

    // Backpressure with ALU busy every cycle
    step(1'b1, alu(5'd10, 32'h100), 1'b1, lsu(5'd20, 32'h200));
    step(1'b1, alu(5'd11, 32'h101), 1'b1, lsu(5'd21, 32'h201));
    check("ready_full", 64'(lsu_ready), 64'h0);
    step(1'b1, alu(5'd12, 32'h102), 1'b1, lsu(5'd22, 32'h202));
    step(1'b1, alu(5'd13, 32'h103), 1'b0, '0);
    idle();
    check("drain1_rd", 64'(rf_rd), 64'd20);
    idle();
    check("drain2_rd", 64'(rf_rd), 64'd21);
    idle();

    // Count 1 with push and pop together; ALU valid without a write lets the queue drain
    step(1'b0, '0, 1'b1, lsu(5'd7, 32'h700));
    b = alu(5'd9, 32'h999);
    b.register_write = 1'b0;
    step(1'b1, b, 1'b1, lsu(5'd8, 32'h800));
    check("count1_pushpop_ready", 64'(lsu_ready), 64'h1);
    check("count1_pushpop_rd", 64'(rf_rd), 64'd7);
    idle();
    z = lsu(5'd0, 32'hDEAD);
    step(1'b0, '0, 1'b1, z);
    idle();
    check("lsu_x0_we", 64'(rf_write_en), 64'h0);
    idle();

    // Redirect with loads queued; the jump link value still writes
    step(1'b1, alu(5'd14, 32'h140), 1'b1, lsu(5'd23, 32'h230));
    b = alu(5'd1, 32'h44);
    b.do_branch = 1'b1; b.branch_target = 32'h80; b.control_flow_pc = 32'h40;
    step(1'b1, b, 1'b1, lsu(5'd24, 32'h240));
    check("br_do_branch", 64'(wb_do_branch), 64'h1);
    check("br_target", 64'(wb_branch_target), 64'h80);
    check("br_icache", 64'(wb_icache_invalidate), 64'h0);
    check("br_btp_valid", 64'(btp_update_valid), 64'(BTP_ON));
    check("br_btp_pc", 64'(btp_update_pc), BTP_ON ? 64'h40 : 64'h0);
    check("br_btp_target", 64'(btp_update_target), BTP_ON ? 64'h80 : 64'h0);
    check("br_link_rd", 64'(rf_rd), 64'd1);
    idle();
    check("br_pulse_end", 64'(wb_do_branch), 64'h0);
    check("br_btp_pulse_end", 64'(btp_update_valid), 64'h0);
    check("br_load1_rd", 64'(rf_rd), 64'd23);
    idle();
    check("br_load2_rd", 64'(rf_rd), 64'd24);

    // Invalidating redirect does not train the predictor
    b = alu(5'd0, 32'h0);
    b.do_branch = 1'b1; b.icache_invalidate = 1'b1; b.branch_target = 32'h200; b.control_flow_pc = 32'h1C;
    step(1'b1, b, 1'b0, '0);
    check("inv_do_branch", 64'(wb_do_branch), 64'h1);
    check("inv_icache", 64'(wb_icache_invalidate), 64'h1);
    check("inv_target", 64'(wb_branch_target), 64'h200);
    check("inv_btp_valid", 64'(btp_update_valid), 64'h0);
    idle();
    check("inv_icache_end", 64'(wb_icache_invalidate), 64'h0);

    // Reset with two queued loads
    step(1'b1, alu(5'd15, 32'h150), 1'b1, lsu(5'd25, 32'h250));
    step(1'b1, alu(5'd16, 32'h160), 1'b1, lsu(5'd26, 32'h260));
    step(1'b1, alu(5'd17, 32'h170), 1'b0, '0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    lsu_model.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(lsu_ready), 64'h1);
    repeat (4) idle();
    check("post_rst_no_write", 64'(rf_write_en), 64'h0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
